song_sequencer: RTL and testbench

- Upstream writer for the note-distribution interface.
- Walks a song stored in synchronous ROM one entry at a time.
- Issues `load_new_note` pulses with note and duration to the note distributor.
- Between chord groups, waits a programmed number of beats.
- Sits between the song-select/play control logic and the note distributor; uses the same 48 Hz `beat` strobe.

---
 rtl/song_pkg.sv | 42 ++++
 rtl/beat_countdown.sv | 48 ++++
 rtl/song_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_song_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
`default_nettype none
// ============================================================================
// Module      : song_pkg
// Description : Shared definitions for the song sequencer and note players:
//               FSM state encoding, ROM word field positions, the end-of-song
//               marker and the note/duration width.
// Revision    : 1.0 - initial release
// ============================================================================
package song_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        WAIT_ROM   = 3'd2,
        DECODE     = 3'd3,
        ISSUE      = 3'd4,
        GAP        = 3'd5,
        WAIT_BEATS = 3'd6,
        DONE       = 3'd7
    } state_t;

    localparam int NOTE_W = 6;

    // ROM word layout: [15] advance, [14:9] note, [8:3] duration/count
    localparam int ADV_BIT  = 15;
    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;

    localparam logic [15:0] END_MARKER = 16'h0000;

    function automatic logic [NOTE_W-1:0] word_note(input logic [15:0] w);
        return w[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [NOTE_W-1:0] word_dur(input logic [15:0] w);
        return w[DUR_MSB:DUR_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/beat_countdown.sv
`default_nettype none
// ============================================================================
// Module      : beat_countdown
// Description : Loadable down-counter that steps once per enabled beat and
//               saturates at zero.
// Ports       : clk, reset (sync, active-high)
//               load / load_val : load a new count (wins over en)
//               en              : decrement strobe (beat qualified by play)
//               count / zero    : current count, count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module beat_countdown #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : song_sequencer
// Description : Walks a song held in synchronous ROM and issues one-cycle
//               load_new_note strobes (note + duration) to the note
//               distributor, waiting programmed beat counts between groups.
// Ports       : clk, reset (sync, active-high), play (0 = freeze),
//               beat (48 Hz strobe), new_song/song (restart select),
//               rom_addr/rom_data (1-cycle latency ROM),
//               load_new_note/note_to_load/duration_to_load, song_done.
// Options     : SONG_LOOP_EN - restart the song at entry 0 on end-of-song
//               instead of returning to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module song_sequencer
    import song_pkg::*;
#(
    parameter int SONG_W  = 2,
    parameter int ENTRY_W = 5,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      beat,
    input  logic                      new_song,
    input  logic [SONG_W-1:0]         song,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [SONG_W+ENTRY_W-1:0] rom_addr,
    output logic                      load_new_note,
    output logic [NOTE_W-1:0]         note_to_load,
    output logic [NOTE_W-1:0]         duration_to_load,
    output logic                      song_done
);

    state_t                    state_q, state_d;
    logic [SONG_W-1:0]         song_q, song_d;
    logic [ENTRY_W-1:0]        index_q, index_d;
    logic                      wrap_q, wrap_d;
    logic [DATA_W-1:0]         rom_word_q, rom_word_d;
    logic [SONG_W+ENTRY_W-1:0] rom_addr_q, rom_addr_d;
    logic                      load_q, load_d;
    logic [NOTE_W-1:0]         note_q, note_d;
    logic [NOTE_W-1:0]         dur_q, dur_d;
    logic                      done_q, done_d;

    logic                      cnt_load;
    logic                      beat_en;
    logic [NOTE_W-1:0]         cnt_count;
    logic                      cnt_zero;
    logic                      is_end;

    // A new_song beat is dropped, and beats only count while waiting.
    assign beat_en = beat && play && !new_song && (state_q == WAIT_BEATS);

    // Having consumed the last index, the following fetch is an end marker.
    assign is_end = (rom_word_q == END_MARKER) || wrap_q;

    beat_countdown #(
        .WIDTH (NOTE_W)
    ) u_countdown (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (word_dur(rom_word_q)),
        .en       (beat_en),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        index_d    = index_q;
        wrap_d     = wrap_q;
        rom_word_d = rom_word_q;
        note_d     = note_q;
        dur_d      = dur_q;
        load_d     = 1'b0;
        done_d     = 1'b0;
        cnt_load   = 1'b0;

        if (new_song) begin
            song_d  = song;
            index_d = '0;
            wrap_d  = 1'b0;
            state_d = FETCH;
        end else if (play) begin
            case (state_q)
                IDLE: ;
                FETCH:    state_d = WAIT_ROM;
                WAIT_ROM: begin
                    rom_word_d = rom_data;
                    state_d    = DECODE;
                end
                DECODE: begin
                    if (is_end) begin
`ifdef SONG_LOOP_EN
                        index_d = '0;
                        wrap_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FETCH;
`else
                        state_d = DONE;
`endif
                    end else if (rom_word_q[ADV_BIT]) begin
                        if (word_dur(rom_word_q) == '0) begin
                            wrap_d  = (index_q == '1);
                            index_d = index_q + ENTRY_W'(1);
                            state_d = FETCH;
                        end else begin
                            cnt_load = 1'b1;
                            state_d  = WAIT_BEATS;
                        end
                    end else begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    load_d  = 1'b1;
                    note_d  = word_note(rom_word_q);
                    dur_d   = word_dur(rom_word_q);
                    wrap_d  = (index_q == '1);
                    index_d = index_q + ENTRY_W'(1);
                    state_d = GAP;
                end
                GAP: state_d = FETCH;
                WAIT_BEATS: begin
                    // zero only guards against a count that is already spent
                    if (cnt_zero || (beat_en && (cnt_count == NOTE_W'(1)))) begin
                        wrap_d  = (index_q == '1);
                        index_d = index_q + ENTRY_W'(1);
                        state_d = FETCH;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        rom_addr_d = {song_d, index_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            song_q     <= '0;
            index_q    <= '0;
            wrap_q     <= 1'b0;
            rom_word_q <= '0;
            rom_addr_q <= '0;
            load_q     <= 1'b0;
            note_q     <= '0;
            dur_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            index_q    <= index_d;
            wrap_q     <= wrap_d;
            rom_word_q <= rom_word_d;
            rom_addr_q <= rom_addr_d;
            load_q     <= load_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign load_new_note    = load_q;
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign song_done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_song_sequencer
// Description : Directed self-checking bench for song_sequencer. A
//               synchronous ROM model holds four songs; each task drives one
//               scenario and checks logged note strobes against hand-computed
//               values and cycle offsets.
// Options     : SONG_LOOP_EN - runs the looping scenario instead of the
//               stop-at-end scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        beat;
    logic        new_song;
    logic [1:0]  song;
    logic [15:0] rom_data;
    logic [6:0]  rom_addr;
    logic        load_new_note;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        song_done;

    logic [15:0] rom_mem [0:127];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ld_note [$];
    int ld_dur  [$];
    int ld_cyc  [$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    song_sequencer #(
        .SONG_W  (2),
        .ENTRY_W (5),
        .DATA_W  (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .beat             (beat),
        .new_song         (new_song),
        .song             (song),
        .rom_data         (rom_data),
        .rom_addr         (rom_addr),
        .load_new_note    (load_new_note),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .song_done        (song_done)
    );

    function automatic logic [15:0] mk_note(input int n, input int d);
        return {1'b0, 6'(n), 6'(d), 3'b000};
    endfunction

    function automatic logic [15:0] mk_adv(input int c);
        return {1'b1, 6'd0, 6'(c), 3'b000};
    endfunction

    // Advance n negedges, logging strobes; pulsed inputs drop after one edge.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (load_new_note === 1'b1) begin
                ld_note.push_back(int'(note_to_load));
                ld_dur.push_back(int'(duration_to_load));
                ld_cyc.push_back(cyc);
            end
            if (song_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            beat     = 1'b0;
            new_song = 1'b0;
        end
    endtask

    task automatic clear_log();
        ld_note.delete();
        ld_dur.delete();
        ld_cyc.delete();
        cyc      = 0;
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic start_song(input int s);
        clear_log();
        song     = 2'(s);
        new_song = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++; if (rom_addr !== 7'h00) $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr); else n_pass++;
        n_checks++; if (load_new_note !== 1'b0) $display("FAIL reset_load: got %0b expected 0", load_new_note); else n_pass++;
        n_checks++; if (note_to_load !== 6'd0) $display("FAIL reset_note: got %0d expected 0", note_to_load); else n_pass++;
        n_checks++; if (duration_to_load !== 6'd0) $display("FAIL reset_dur: got %0d expected 0", duration_to_load); else n_pass++;
        n_checks++; if (song_done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", song_done); else n_pass++;
    endtask

    task automatic test_two_notes();
        start_song(1);
        cycles(30);
        n_checks++; if (ld_note.size() != 2) $display("FAIL two_notes_count: got %0d expected 2", ld_note.size()); else n_pass++;
        n_checks++; if (ld_note[0] != 12 || ld_dur[0] != 8) $display("FAIL two_notes_first: got (%0d,%0d) expected (12,8)", ld_note[0], ld_dur[0]); else n_pass++;
        n_checks++; if (ld_note[1] != 20 || ld_dur[1] != 4) $display("FAIL two_notes_second: got (%0d,%0d) expected (20,4)", ld_note[1], ld_dur[1]); else n_pass++;
        n_checks++; if (ld_cyc[0] != 5 || ld_cyc[1] != 10) $display("FAIL two_notes_timing: got cycles %0d,%0d expected 5,10", ld_cyc[0], ld_cyc[1]); else n_pass++;
        n_checks++; if (done_cnt != 1 || done_cyc != 15) $display("FAIL two_notes_done: got %0d pulses at %0d expected 1 at 15", done_cnt, done_cyc); else n_pass++;
        n_checks++; if (rom_addr !== 7'h22) $display("FAIL two_notes_addr: got %0h expected 22", rom_addr); else n_pass++;
        n_checks++; if (note_to_load !== 6'd20 || duration_to_load !== 6'd4) $display("FAIL two_notes_hold: got (%0d,%0d) expected (20,4)", note_to_load, duration_to_load); else n_pass++;
    endtask

    task automatic test_pause_issue();
        start_song(1);
        cycles(4);
        play = 1'b0;
        cycles(6);
        n_checks++; if (ld_note.size() != 0) $display("FAIL pause_issue_held: got %0d loads expected 0", ld_note.size()); else n_pass++;
        play = 1'b1;
        cycles(1);
        n_checks++; if (ld_note.size() != 1 || ld_cyc[0] != 11 || ld_note[0] != 12) $display("FAIL pause_issue_resume: got %0d loads at %0d note %0d expected 1 at 11 note 12", ld_note.size(), ld_cyc[0], ld_note[0]); else n_pass++;
        cycles(20);
    endtask

    task automatic test_beat_wait();
        int st;
        start_song(2);
        cycles(5);
        cycles(6);
        beat = 1'b1; cycles(4);
        beat = 1'b1; cycles(8);
        n_checks++; if (ld_note.size() != 1) $display("FAIL beat_wait_early: got %0d loads expected 1", ld_note.size()); else n_pass++;
        beat = 1'b1;
        st = cyc;
        cycles(5);
        n_checks++; if (ld_note.size() != 2 || ld_cyc[1] != st + 5) $display("FAIL beat_wait_latency: got %0d loads, last at %0d expected 2 at %0d", ld_note.size(), ld_cyc[1], st + 5); else n_pass++;
        n_checks++; if (ld_note[1] != 11 || ld_dur[1] != 5) $display("FAIL beat_wait_note: got (%0d,%0d) expected (11,5)", ld_note[1], ld_dur[1]); else n_pass++;
        cycles(10);
        n_checks++; if (done_cnt != 1) $display("FAIL beat_wait_done: got %0d expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_pause_beats();
        int st;
        start_song(3);
        cycles(5);
        play = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat = 1'b1;
            cycles(2);
        end
        play = 1'b1;
        cycles(3);
        beat = 1'b1;
        cycles(3);
        n_checks++; if (ld_note.size() != 0) $display("FAIL pause_beats_hold: got %0d loads expected 0", ld_note.size()); else n_pass++;
        beat = 1'b1;
        st = cyc;
        cycles(5);
        n_checks++; if (ld_note.size() != 1 || ld_cyc[0] != st + 5 || ld_note[0] != 33 || ld_dur[0] != 7) $display("FAIL pause_beats_resume: got %0d loads at %0d (%0d,%0d) expected 1 at %0d (33,7)", ld_note.size(), ld_cyc[0], ld_note[0], ld_dur[0], st + 5); else n_pass++;
        cycles(10);
    endtask

    task automatic test_abort();
        start_song(2);
        cycles(11);
        clear_log();
        song     = 2'd1;
        new_song = 1'b1;
        beat     = 1'b1;
        cycles(1);
        n_checks++; if (rom_addr !== 7'h20) $display("FAIL abort_addr: got %0h expected 20", rom_addr); else n_pass++;
        cycles(30);
        n_checks++; if (ld_note.size() != 2 || ld_note[0] != 12 || ld_note[1] != 20) $display("FAIL abort_notes: got %0d loads first %0d expected 2 loads 12,20", ld_note.size(), ld_note[0]); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL abort_done: got %0d expected 1", done_cnt); else n_pass++;
    endtask

    task automatic test_full_song();
        int bad;
        start_song(0);
        cycles(180);
        bad = 0;
        foreach (ld_note[i]) if (ld_note[i] != i + 1 || ld_dur[i] != (i % 8) + 1) bad++;
        n_checks++; if (ld_note.size() != 32) $display("FAIL full_song_count: got %0d expected 32", ld_note.size()); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL full_song_values: got %0d wrong entries expected 0", bad); else n_pass++;
        n_checks++; if (done_cnt != 1 || done_cyc != 165) $display("FAIL full_song_done: got %0d pulses at %0d expected 1 at 165", done_cnt, done_cyc); else n_pass++;
    endtask

`ifdef SONG_LOOP_EN
    task automatic test_loop();
        start_song(1);
        cycles(38);
        n_checks++; if (ld_note.size() != 6) $display("FAIL loop_count: got %0d expected 6", ld_note.size()); else n_pass++;
        n_checks++; if (ld_note[2] != 12 || ld_note[3] != 20 || ld_cyc[2] != 18) $display("FAIL loop_repeat: got %0d,%0d at %0d expected 12,20 at 18", ld_note[2], ld_note[3], ld_cyc[2]); else n_pass++;
        n_checks++; if (done_cnt != 2) $display("FAIL loop_done: got %0d expected 2", done_cnt); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_song();
        start_song(1);
        cycles(6);
        reset = 1'b1;
        cycles(1);
        n_checks++; if (rom_addr !== 7'h00) $display("FAIL midreset_addr: got %0h expected 0", rom_addr); else n_pass++;
        n_checks++; if (note_to_load !== 6'd0 || duration_to_load !== 6'd0) $display("FAIL midreset_note: got (%0d,%0d) expected (0,0)", note_to_load, duration_to_load); else n_pass++;
        n_checks++; if (load_new_note !== 1'b0 || song_done !== 1'b0) $display("FAIL midreset_strobes: got %0b%0b expected 00", load_new_note, song_done); else n_pass++;
        reset = 1'b0;
        clear_log();
        cycles(20);
        n_checks++; if (ld_note.size() != 0 || done_cnt != 0) $display("FAIL midreset_idle: got %0d loads %0d done expected 0 0", ld_note.size(), done_cnt); else n_pass++;
    endtask

    initial begin
        for (int a = 0; a < 128; a++) rom_mem[a] = 16'h0000;
        for (int i = 0; i < 32; i++) rom_mem[i] = mk_note(i + 1, (i % 8) + 1);
        rom_mem[32 + 0] = mk_note(12, 8);
        rom_mem[32 + 1] = mk_note(20, 4);
        rom_mem[64 + 0] = mk_note(10, 3);
        rom_mem[64 + 1] = mk_adv(3);
        rom_mem[64 + 2] = mk_note(11, 5);
        rom_mem[96 + 0] = mk_adv(2);
        rom_mem[96 + 1] = mk_note(33, 7);

        reset    = 1'b1;
        play     = 1'b1;
        beat     = 1'b0;
        new_song = 1'b0;
        song     = 2'd0;
        cycles(3);
        test_reset();
        reset = 1'b0;
        cycles(2);
`ifdef SONG_LOOP_EN
        test_loop();
`else
        test_two_notes();
        test_pause_issue();
        test_beat_wait();
        test_pause_beats();
        test_abort();
        test_full_song();
`endif
        test_reset_mid_song();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
